// File: rtl/uart_rx.sv
// UART receiver: start, 8 data bits LSB first, parity, stop; one-cycle valid/frame-error pulses.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority voting around every sample point.
module uart_rx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY       = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       rx_busy
);
  localparam int            CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int            MID      = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(MID - 1);
  localparam logic          PAR_ODD  = (PARITY != 0);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_BREAK  = 3'd5;

  logic sync_meta;
  logic rx_s;
  logic samp;

`ifdef UART_RX_MAJORITY_EN
  // One extra stage gives a settled look-ahead tap, so the vote spans
  // sample point -1/0/+1 without moving any decision relative to the frame.
  logic rx_ahead;
  logic rx_d;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) {sync_meta, rx_ahead, rx_s, rx_d} <= 4'b1111;
    else        {sync_meta, rx_ahead, rx_s, rx_d} <= {rx, sync_meta, rx_ahead, rx_s};
  end
  assign samp = (rx_ahead & rx_s) | (rx_ahead & rx_d) | (rx_s & rx_d);
`else
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) {sync_meta, rx_s} <= 2'b11;
    else        {sync_meta, rx_s} <= {rx, sync_meta};
  end
  assign samp = rx_s;
`endif

  logic [2:0]    state;
  logic [CW-1:0] bit_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          p_bit;
  logic          at_sample;

  assign at_sample = (bit_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      p_bit      <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      rx_busy    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state   <= S_START;
            bit_cnt <= '0;
            rx_busy <= 1'b1;
          end
        end
        // Confirm the start bit half a bit in; later samples then land mid-bit.
        S_START: begin
          if (bit_cnt == CNT_MID) begin
            if (samp) begin
              state   <= S_IDLE;
              rx_busy <= 1'b0;
            end else begin
              state   <= S_DATA;
              bit_cnt <= '0;
              bit_idx <= '0;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (at_sample) begin
            bit_cnt        <= '0;
            shift[bit_idx] <= samp;
            bit_idx        <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= S_PARITY;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (at_sample) begin
            bit_cnt <= '0;
            p_bit   <= samp;
            state   <= S_STOP;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        // Leaving at the stop mid-point leaves half a bit to catch a back-to-back start.
        S_STOP: begin
          if (at_sample) begin
            bit_cnt <= '0;
            if (samp) begin
              data_out   <= shift;
              data_valid <= 1'b1;
              parity_err <= p_bit ^ (^shift) ^ PAR_ODD;
              state      <= S_IDLE;
              rx_busy    <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= S_BREAK;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        S_BREAK: begin
          if (rx_s) begin
            state   <= S_IDLE;
            rx_busy <= 1'b0;
          end
        end
        default: begin
          state   <= S_IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: a waveform is built up front, a frame-level model predicts every
// output cycle, then the waveform is replayed and the DUT compared cycle by cycle.
module tb_uart_rx;
  localparam int C    = 4;
  localparam int PAR  = 0;
  localparam int MID  = C / 2;
  localparam bit PODD = (PAR != 0);
`ifdef UART_RX_MAJORITY_EN
  localparam bit MAJ  = 1'b1;
  localparam int ND   = 8;
`else
  localparam bit MAJ  = 1'b0;
  localparam int ND   = 7;
`endif
  localparam int NMAX = 12000;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       rx    = 1'b1;
  logic [7:0] data_out;
  logic       data_valid, parity_err, frame_err, rx_busy;

  uart_rx #(.CLKS_PER_BIT(C), .PARITY(PAR)) dut (
    .clk(clk), .reset(reset), .rx(rx), .data_out(data_out), .data_valid(data_valid),
    .parity_err(parity_err), .frame_err(frame_err), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  // L[k]/RST[k]: line level and reset state across clock edge k.
  bit         L [NMAX];
  bit         RST [NMAX];
  bit         R [NMAX];
  bit         e_busy [NMAX];
  bit         e_valid [NMAX];
  bit         e_perr [NMAX];
  bit         e_ferr [NMAX];
  logic [7:0] e_byte [NMAX];
  logic [7:0] e_data [NMAX];
  int         n = 0;
  int         n_ok = 0, n_fe = 0;
  int         checks = 0, errors = 0;
  int         dut_fe = 0;
  logic [7:0] got_b[$];
  logic       got_p[$];

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, k, act, exp);
    end
  endtask

  task automatic put(input bit v, input bit r = 1'b0);
    L[n] = v; RST[n] = r; n++;
  endtask

  task automatic idle(input int cyc);
    repeat (cyc) put(1'b1);
  endtask

  task automatic frame(input logic [7:0] b, input bit bad_par, input bit stop, input bit glitch);
    logic [10:0] bits;
    bits = {stop, (^b) ^ PODD ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++)
      for (int c = 0; c < C; c++)
        put((glitch && i >= 1 && i <= 8 && c == MID) ? ~bits[i] : bits[i]);
    if (stop) n_ok++; else n_fe++;
  endtask

  function automatic bit samp(input int k);
    bit a, c;
    if (!MAJ) return R[k];
    a = R[k-1];
    c = (k + 1 < n) ? R[k+1] : 1'b1;
    return (a & R[k]) | (a & c) | (R[k] & c);
  endfunction

  task automatic set_busy(input int a, input int b);
    for (int j = a; j < b && j < n; j++) e_busy[j] = 1'b1;
  endtask

  // Frame-level prediction: find start edges, derive sample instants arithmetically.
  task automatic build_model();
    bit s1, s2, s3, p;
    int k, k0, chk_e, stp, r, j;
    logic [7:0] b, h;
    s1 = 1; s2 = 1; s3 = 1;
    for (int i = 0; i < n; i++) begin
      R[i] = MAJ ? s3 : s2;
      if (RST[i]) {s1, s2, s3} = 3'b111;
      else        {s1, s2, s3} = {L[i], s1, s2};
      e_busy[i] = 0; e_valid[i] = 0; e_perr[i] = 0; e_ferr[i] = 0; e_byte[i] = '0;
    end
    k = 0;
    while (k < n) begin
      if (RST[k] || R[k]) begin k++; continue; end
      k0 = k; chk_e = k0 + MID; stp = chk_e + 10 * C;
      r = n;
      for (int q = k0 + 1; q < n; q++) if (RST[q]) begin r = q; break; end
      if (chk_e >= r) begin set_busy(k0, r); k = r; continue; end
      if (samp(chk_e)) begin set_busy(k0, chk_e); k = chk_e + 1; continue; end
      if (stp >= r) begin set_busy(k0, r); k = r; continue; end
      for (int i = 0; i < 8; i++) b[i] = samp(chk_e + C * (i + 1));
      p = samp(chk_e + 9 * C);
      if (samp(stp)) begin
        set_busy(k0, stp);
        e_valid[stp] = 1; e_byte[stp] = b; e_perr[stp] = p ^ (^b) ^ PODD;
        k = stp + 1;
      end else begin
        e_ferr[stp] = 1;
        j = stp + 1;
        while (j < n && !RST[j] && !R[j]) j++;
        set_busy(k0, j);
        k = (j < n && !RST[j]) ? j + 1 : j;
      end
    end
    h = '0;
    for (int i = 0; i < n; i++) begin
      if (RST[i]) h = '0;
      else if (e_valid[i]) h = e_byte[i];
      e_data[i] = h;
    end
  endtask

  task automatic check_cycle(input int k);
    chk("data_valid", k, data_valid, e_valid[k]);
    chk("parity_err", k, parity_err, e_perr[k]);
    chk("frame_err", k, frame_err, e_ferr[k]);
    chk("rx_busy", k, rx_busy, e_busy[k]);
    chk("data_out", k, data_out, e_data[k]);
    if (data_valid === 1'b1) begin got_b.push_back(data_out); got_p.push_back(parity_err); end
    if (frame_err === 1'b1) dut_fe++;
  endtask

  logic [7:0] lit_b [8];
  logic       lit_p [8];

  initial begin
    logic [10:0] pb;
    logic [7:0]  b;
    bit          st, prev_bad;
    lit_b = '{8'hA5, 8'h3C, 8'h55, 8'h00, 8'hFF, 8'h12, 8'h7E, 8'hC3};
    lit_p = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    repeat (4) put(1'b1, 1'b1);
    idle(8);
    frame(8'hA5, 0, 1, 0); idle(6);
    frame(8'h3C, 1, 1, 0); idle(6);
    frame(8'h81, 0, 0, 0); repeat (40) put(1'b0); idle(6);
    frame(8'h55, 0, 1, 0); idle(6);
    put(1'b0); idle(10);
    frame(8'h00, 0, 1, 0); frame(8'hFF, 0, 1, 0); frame(8'h12, 0, 1, 0); idle(6);
    pb = {1'b1, 1'b0, 8'h99, 1'b0};
    for (int i = 0; i < 5 * C + 2; i++) put(pb[i / C]);
    repeat (3) put(1'b1, 1'b1);
    idle(6);
    frame(8'h7E, 0, 1, 0); idle(6);
    if (MAJ) begin frame(8'hC3, 0, 1, 1); idle(6); end

    prev_bad = 0;
    for (int f = 0; f < 60; f++) begin
      b  = 8'($urandom_range(0, 255));
      st = ($urandom_range(0, 7) != 0);
      if (prev_bad) idle(C);
      idle($urandom_range(0, 6));
      if ($urandom_range(0, 5) == 0) begin put(1'b0); idle(MID + 2); end
      frame(b, $urandom_range(0, 3) == 0, st, MAJ && ($urandom_range(0, 1) == 1));
      prev_bad = !st;
    end
    idle(C + 8);

    build_model();

    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k > 0) check_cycle(k - 1);
      if (k > 0 && RST[k] && !RST[k-1]) begin
        chk("busy_before_reset", k, rx_busy, 1'b1);
        rx = L[k]; reset = 1'b0;
        #1;
        chk("reset_data_out", k, data_out, 8'h00);
        chk("reset_busy", k, rx_busy, 1'b0);
        chk("reset_valid", k, data_valid, 1'b0);
      end else begin
        rx = L[k]; reset = ~RST[k];
      end
    end
    @(negedge clk);
    check_cycle(n - 1);

    for (int i = 0; i < ND; i++) begin
      chk("lit_byte", i, (i < got_b.size()) ? got_b[i] : 8'hxx, lit_b[i]);
      chk("lit_parity", i, (i < got_p.size()) ? got_p[i] : 1'bx, lit_p[i]);
    end
    chk("valid_count", n, got_b.size(), n_ok);
    chk("frame_err_count", n, dut_fe, n_fe);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
